// File: rtl/mems_dac_sequencer_pkg.sv
// ============================================================================
// Module   : mems_dac_pkg
// Purpose  : DAC command/address codes, frame indices and sequencer state type
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mems_dac_pkg;

    localparam logic [2:0] CMD_WR_N         = 3'b000;
    localparam logic [2:0] CMD_WR_N_UPD_ALL = 3'b010;
    localparam logic [2:0] CMD_WR_UPD_N     = 3'b011;
    localparam logic [2:0] CMD_RESET        = 3'b101;

    localparam logic [2:0] ADDR_A   = 3'b000;
    localparam logic [2:0] ADDR_B   = 3'b001;
    localparam logic [2:0] ADDR_C   = 3'b010;
    localparam logic [2:0] ADDR_D   = 3'b011;
    localparam logic [2:0] ADDR_ALL = 3'b111;

    localparam logic [2:0] FRM_SOFT_RST  = 3'd0;
    localparam logic [2:0] FRM_INIT_BIAS = 3'd1;
    localparam logic [2:0] FRM_A         = 3'd2;
    localparam logic [2:0] FRM_B         = 3'd3;
    localparam logic [2:0] FRM_C         = 3'd4;
    localparam logic [2:0] FRM_D         = 3'd5;

    localparam logic [15:0] SOFT_RST_DATA = 16'h0001;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    function automatic logic [23:0] make_frame(input logic [2:0]  cmd,
                                               input logic [2:0]  addr,
                                               input logic [15:0] data);
        return {2'b00, cmd, addr, data};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mems_dac_sequencer_clamp.sv
// ============================================================================
// Module   : mems_code_clamp
// Purpose  : base +/- signed delta in 18-bit signed arithmetic, saturated to [0, VMAX]
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mems_code_clamp #(
    parameter logic [15:0] VMAX = 16'd60000
) (
    input  logic        [15:0] base_i,
    input  logic signed [15:0] delta_i,
    input  logic               subtract_i,
    output logic        [15:0] code_o
);

    logic signed [17:0] w_delta;
    logic signed [17:0] w_sum;

    assign w_delta = {{2{delta_i[15]}}, delta_i};
    // 18 bits cover the full range 0x8000 +/- (-32768) without wrapping
    assign w_sum   = subtract_i ? ($signed({2'b00, base_i}) - w_delta)
                                : ($signed({2'b00, base_i}) + w_delta);

    always_comb begin
        code_o = w_sum[15:0];
        if (w_sum < 18'sd0) begin
            code_o = 16'd0;
        end else if (w_sum > $signed({2'b00, VMAX})) begin
            code_o = VMAX;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mems_dac_sequencer.sv
// ============================================================================
// Module   : mems_dac_sequencer
// Purpose  : Converts X/Y mirror positions into four clamped DAC frames for the SPI master
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mems_dac_sequencer
    import mems_dac_pkg::*;
#(
    parameter logic [15:0] BIAS = 16'h8000,
    parameter logic [15:0] VMAX = 16'd60000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pos_valid,
    output logic               pos_ready,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    output logic               update_done,
    output logic               spi_start,
    output logic        [23:0] spi_data,
    input  logic               spi_busy,
    input  logic               spi_new_data
);

    state_t             state_q, state_d;
    logic [2:0]         index_q, index_d;
    logic [3:0][15:0]   code_q, code_d;
    logic               spi_start_q, spi_start_d;
    logic [23:0]        spi_data_q, spi_data_d;
    logic               update_done_q, update_done_d;

    logic [3:0][15:0]   w_code;
    logic [23:0]        w_frame;

    // Channel order A..D: BIAS+x, BIAS-x, BIAS+y, BIAS-y
    for (genvar g = 0; g < 4; g++) begin : g_clamp
        mems_code_clamp #(
            .VMAX (VMAX)
        ) u_clamp (
            .base_i     (BIAS),
            .delta_i    ((g < 2) ? x_in : y_in),
            .subtract_i ((g % 2) == 1),
            .code_o     (w_code[g])
        );
    end

    always_comb begin
        w_frame = 24'h000000;
        case (index_q)
            FRM_SOFT_RST:  w_frame = make_frame(CMD_RESET,        ADDR_A,   SOFT_RST_DATA);
            FRM_INIT_BIAS: w_frame = make_frame(CMD_WR_UPD_N,     ADDR_ALL, BIAS);
            FRM_A:         w_frame = make_frame(CMD_WR_N,         ADDR_A,   code_q[0]);
            FRM_B:         w_frame = make_frame(CMD_WR_N,         ADDR_B,   code_q[1]);
            FRM_C:         w_frame = make_frame(CMD_WR_N,         ADDR_C,   code_q[2]);
            FRM_D:         w_frame = make_frame(CMD_WR_N_UPD_ALL, ADDR_D,   code_q[3]);
            default:       w_frame = 24'h000000;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        code_d        = code_q;
        spi_start_d   = 1'b0;
        spi_data_d    = spi_data_q;
        update_done_d = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                if (!spi_busy) begin
                    spi_start_d = 1'b1;
                    spi_data_d  = w_frame;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (spi_new_data) begin
                    if (index_q == FRM_INIT_BIAS) begin
                        state_d = ST_IDLE;
                    end else if (index_q == FRM_D) begin
                        state_d       = ST_IDLE;
                        update_done_d = 1'b1;
                    end else begin
                        index_d = index_q + 3'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_IDLE: begin
                if (pos_valid) begin
                    code_d  = w_code;
                    index_d = FRM_A;
                    // Issue frame A straight from the acceptance edge so it starts one cycle later
                    if (!spi_busy) begin
                        spi_start_d = 1'b1;
                        spi_data_d  = make_frame(CMD_WR_N, ADDR_A, w_code[0]);
                        state_d     = ST_WAIT;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_ISSUE;
                index_d = FRM_SOFT_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ISSUE;
            index_q       <= FRM_SOFT_RST;
            code_q        <= '0;
            spi_start_q   <= 1'b0;
            spi_data_q    <= 24'h000000;
            update_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            code_q        <= code_d;
            spi_start_q   <= spi_start_d;
            spi_data_q    <= spi_data_d;
            update_done_q <= update_done_d;
        end
    end

    assign pos_ready   = (state_q == ST_IDLE);
    assign spi_start   = spi_start_q;
    assign spi_data    = spi_data_q;
    assign update_done = update_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mems_dac_sequencer.sv
// ============================================================================
// Module   : tb_mems_dac_sequencer
// Purpose  : Directed self-checking bench for mems_dac_sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mems_dac_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               pos_valid;
    logic               pos_ready;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic               update_done;
    logic               spi_start;
    logic [23:0]        spi_data;
    logic               spi_busy;
    logic               spi_new_data;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mems_dac_sequencer #(
        .BIAS (16'h8000),
        .VMAX (16'd60000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pos_valid    (pos_valid),
        .pos_ready    (pos_ready),
        .x_in         (x_in),
        .y_in         (y_in),
        .update_done  (update_done),
        .spi_start    (spi_start),
        .spi_data     (spi_data),
        .spi_busy     (spi_busy),
        .spi_new_data (spi_new_data)
    );

    // Acts as the SPI master for one frame: waits for start, checks data, completes it.
    task automatic serve_frame(input logic [23:0] exp, input string nm);
        bit found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (spi_start === 1'b1) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL %s: spi_start timeout, data=%h required=%h", nm, spi_data, exp);
        end else if (spi_data !== exp) begin
            fails++;
            $display("FAIL %s: spi_data=%h required=%h", nm, spi_data, exp);
        end
        spi_busy = 1'b1;
        @(negedge clk);
        checks++;
        if (spi_start !== 1'b0) begin
            fails++;
            $display("FAIL %s_start_width: spi_start=%b required=0", nm, spi_start);
        end
        repeat (2) @(negedge clk);
        spi_new_data = 1'b1;
        spi_busy     = 1'b0;
        @(negedge clk);
        spi_new_data = 1'b0;
    endtask

    task automatic send_pos(input logic [15:0] x, input logic [15:0] y);
        checks++;
        if (pos_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_pos_ready: pos_ready=%b required=1", pos_ready);
        end
        pos_valid = 1'b1;
        x_in      = x;
        y_in      = y;
        @(posedge clk);
        #1;
        pos_valid = 1'b0;
        x_in      = 16'h5A5A;
        y_in      = 16'hA5A5;
    endtask

    task automatic check_done(input string nm);
        checks++;
        if (update_done !== 1'b1 || pos_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s: update_done=%b pos_ready=%b required 1/1", nm, update_done, pos_ready);
        end
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        pos_valid    = 1'b0;
        x_in         = 16'h0;
        y_in         = 16'h0;
        spi_busy     = 1'b0;
        spi_new_data = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pos_ready !== 1'b0 || spi_start !== 1'b0 || spi_data !== 24'h0 || update_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: ready=%b start=%b data=%h done=%b required 0/0/000000/0",
                     pos_ready, spi_start, spi_data, update_done);
        end
        rst = 1'b0;
        serve_frame(24'h280001, "init_soft_reset");
        checks++;
        if (pos_ready !== 1'b0) begin
            fails++;
            $display("FAIL init_ready_early: pos_ready=%b required=0", pos_ready);
        end
        serve_frame(24'h1F8000, "init_bias");
        checks++;
        if (pos_ready !== 1'b1 || update_done !== 1'b0) begin
            fails++;
            $display("FAIL init_ready: pos_ready=%b update_done=%b required 1/0", pos_ready, update_done);
        end
    endtask

    task automatic test_main;
        send_pos(16'h1000, 16'hF000);
        serve_frame(24'h009000, "main_A");
        serve_frame(24'h017000, "main_B");
        serve_frame(24'h027000, "main_C");
        serve_frame(24'h139000, "main_D");
        check_done("main_done");
        @(negedge clk);
        checks++;
        if (update_done !== 1'b0) begin
            fails++;
            $display("FAIL main_done_pulse: update_done=%b required=0", update_done);
        end
        // Stray completion pulse in IDLE must not disturb anything
        spi_new_data = 1'b1;
        @(negedge clk);
        spi_new_data = 1'b0;
        @(negedge clk);
        checks++;
        if (spi_start !== 1'b0 || pos_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_new_data: start=%b ready=%b required 0/1", spi_start, pos_ready);
        end
    endtask

    task automatic test_saturation;
        send_pos(16'h7FFF, 16'h0000);
        serve_frame(24'h00EA60, "sat_pos_A");
        serve_frame(24'h010001, "sat_pos_B");
        serve_frame(24'h028000, "sat_pos_C");
        serve_frame(24'h138000, "sat_pos_D");
        check_done("sat_pos_done");
        @(negedge clk);
        send_pos(16'h8000, 16'h0000);
        serve_frame(24'h000000, "sat_neg_A");
        serve_frame(24'h01EA60, "sat_neg_B");
        serve_frame(24'h028000, "sat_neg_C");
        serve_frame(24'h138000, "sat_neg_D");
        check_done("sat_neg_done");
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        pos_valid = 1'b1;
        x_in      = 16'h1000;
        y_in      = 16'h0000;
        @(posedge clk);
        #1;
        x_in = 16'h2000;
        serve_frame(24'h009000, "b2b_first_A");
        checks++;
        if (pos_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_ready_mid: pos_ready=%b required=0", pos_ready);
        end
        serve_frame(24'h017000, "b2b_first_B");
        serve_frame(24'h028000, "b2b_first_C");
        serve_frame(24'h138000, "b2b_first_D");
        check_done("b2b_first_done");
        @(posedge clk);
        #1;
        pos_valid = 1'b0;
        serve_frame(24'h00A000, "b2b_second_A");
        serve_frame(24'h016000, "b2b_second_B");
        serve_frame(24'h028000, "b2b_second_C");
        serve_frame(24'h138000, "b2b_second_D");
        check_done("b2b_second_done");
        @(negedge clk);
    endtask

    task automatic test_busy_hold;
        int early = 0;
        int bad_data = 0;
        spi_busy = 1'b1;
        send_pos(16'h0010, 16'h0020);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (spi_start !== 1'b0) early++;
            if (spi_data !== 24'h138000) bad_data++;
        end
        checks++;
        if (early != 0 || bad_data != 0) begin
            fails++;
            $display("FAIL busy_hold: starts=%0d data_changes=%0d required 0/0", early, bad_data);
        end
        spi_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (spi_start !== 1'b1 || spi_data !== 24'h008010) begin
            fails++;
            $display("FAIL busy_release: start=%b data=%h required 1/008010", spi_start, spi_data);
        end
        spi_busy = 1'b1;
        repeat (2) @(negedge clk);
        spi_new_data = 1'b1;
        spi_busy     = 1'b0;
        @(negedge clk);
        spi_new_data = 1'b0;
        serve_frame(24'h017FF0, "busy_B");
        serve_frame(24'h028020, "busy_C");
        serve_frame(24'h137FE0, "busy_D");
        check_done("busy_done");
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        send_pos(16'h0100, 16'h0000);
        serve_frame(24'h008100, "rstmid_A");
        serve_frame(24'h017F00, "rstmid_B");
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (spi_start === 1'b1) break;
        end
        checks++;
        if (spi_start !== 1'b1 || spi_data !== 24'h028000) begin
            fails++;
            $display("FAIL rstmid_C: start=%b data=%h required 1/028000", spi_start, spi_data);
        end
        spi_busy = 1'b1;
        @(negedge clk);
        rst      = 1'b1;
        spi_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (spi_start !== 1'b0 || pos_ready !== 1'b0 || spi_data !== 24'h0 || update_done !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_values: start=%b ready=%b data=%h done=%b required 0/0/000000/0",
                     spi_start, pos_ready, spi_data, update_done);
        end
        rst = 1'b0;
        serve_frame(24'h280001, "rstmid_soft_reset");
        serve_frame(24'h1F8000, "rstmid_bias");
        checks++;
        if (pos_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_ready: pos_ready=%b required=1", pos_ready);
        end
    endtask

    initial begin
        test_reset();
        test_main();
        test_saturation();
        test_back_to_back();
        test_busy_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
